command_receiver: RTL and testbench

Downstream stage of the UART receiver. Assembles the two-byte request frame (command code, then sensor address) from the receiver's one-cycle byte strobes, validates both fields, and presents a complete command to the sensor controller over a valid/ready handshake. Malformed, stale, or overrunning frames are discarded and reported as one-cycle error pulses.

---
 rtl/command_pkg.sv | 30 +++
 rtl/timeout_counter.sv | 24 ++
 rtl/command_receiver.sv | 123 ++++++++++++
 tb/tb_command_receiver.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/command_pkg.sv
// Shared definitions for the sensor command path: command codes, error causes, FSM encodings.
// Imported by both the command receiver and the sensor controller.
package command_pkg;

    localparam logic [7:0] CMD_STATUS         = 8'h00;
    localparam logic [7:0] CMD_TEMP           = 8'h01;
    localparam logic [7:0] CMD_HUMID          = 8'h02;
    localparam logic [7:0] CMD_TEMP_CONT_ON   = 8'h03;
    localparam logic [7:0] CMD_HUMID_CONT_ON  = 8'h04;
    localparam logic [7:0] CMD_TEMP_CONT_OFF  = 8'h05;
    localparam logic [7:0] CMD_HUMID_CONT_OFF = 8'h06;
    localparam logic [7:0] CMD_MAX            = 8'h06;

    localparam logic [1:0] ERR_OVERRUN         = 2'b00;
    localparam logic [1:0] ERR_INVALID_COMMAND = 2'b01;
    localparam logic [1:0] ERR_INVALID_ADDRESS = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT         = 2'b11;

    typedef enum logic [1:0] {
        ST_WAIT_COMMAND = 2'b00,
        ST_WAIT_ADDRESS = 2'b01,
        ST_HOLD         = 2'b10
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] address;
    } cmd_t;

endpackage

// File: rtl/timeout_counter.sv
// Clear/enable up-counter that saturates at LAST and flags it with expired.
module timeout_counter #(
    parameter int unsigned WIDTH = 16,
    parameter logic [WIDTH-1:0] LAST = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             expired
);

    assign expired = (count == LAST);

    // Holding at LAST keeps the counter from wrapping if the owner lingers.
    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/command_receiver.sv
// Assembles the two-byte command frame from UART byte strobes, validates it and
// offers it downstream on a valid/ready handshake; discarded frames raise one-cycle errors.
module command_receiver
    import command_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLOCKS = 43400,
    parameter int unsigned MAX_ADDRESS    = 31
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       has_data,
    input  logic [7:0] data_received,
    input  logic       command_ready,
    output logic       command_valid,
    output logic [7:0] command_code,
    output logic [7:0] sensor_address,
    output logic       error_flag,
    output logic [1:0] error_code,
    output logic [1:0] debug_state
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CLOCKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLOCKS - 1);
    localparam logic [7:0]       ADDR_MAX = 8'(MAX_ADDRESS);

    state_t           state, next_state;
    cmd_t             cmd_q, cmd_d;
    logic             valid_d;
    logic             err_flag_d;
    logic [1:0]       err_code_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_expired;

    // Counter sits at zero outside WAIT_ADDRESS, so entering it always starts a fresh window.
    timeout_counter #(
        .WIDTH (CNT_W),
        .LAST  (CNT_LAST)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (state != ST_WAIT_ADDRESS),
        .enable  (!has_data),
        .count   (cnt),
        .expired (cnt_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_WAIT_COMMAND;
            cmd_q         <= '0;
            command_valid <= 1'b0;
            error_flag    <= 1'b0;
            error_code    <= 2'b00;
            debug_state   <= 2'b00;
        end else begin
            state         <= next_state;
            cmd_q         <= cmd_d;
            command_valid <= valid_d;
            error_flag    <= err_flag_d;
            error_code    <= err_code_d;
            debug_state   <= state;
        end
    end

    always_comb begin
        next_state = state;
        cmd_d      = cmd_q;
        valid_d    = command_valid;
        err_flag_d = 1'b0;
        err_code_d = 2'b00;
        case (state)
            ST_WAIT_COMMAND: begin
                if (has_data) begin
                    if (data_received <= CMD_MAX) begin
                        cmd_d.code = data_received;
                        next_state = ST_WAIT_ADDRESS;
                    end else begin
                        err_flag_d = 1'b1;
                        err_code_d = ERR_INVALID_COMMAND;
                    end
                end
            end
            ST_WAIT_ADDRESS: begin
                // A byte in the expiry cycle takes priority over the timeout.
                if (has_data) begin
                    if (data_received <= ADDR_MAX) begin
                        cmd_d.address = data_received;
                        valid_d       = 1'b1;
                        next_state    = ST_HOLD;
                    end else begin
                        cmd_d      = '0;
                        err_flag_d = 1'b1;
                        err_code_d = ERR_INVALID_ADDRESS;
                        next_state = ST_WAIT_COMMAND;
                    end
                end else if (cnt_expired) begin
                    cmd_d      = '0;
                    err_flag_d = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    next_state = ST_WAIT_COMMAND;
                end
            end
            ST_HOLD: begin
                if (has_data) begin
                    err_flag_d = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end
                if (command_valid && command_ready) begin
                    valid_d    = 1'b0;
                    next_state = ST_WAIT_COMMAND;
                end
            end
            default: begin
                valid_d    = 1'b0;
                next_state = ST_WAIT_COMMAND;
            end
        endcase
    end

    assign command_code   = cmd_q.code;
    assign sensor_address = cmd_q.address;

endmodule

// File: tb/tb_command_receiver.sv
// Directed scenarios plus randomized frames checked against a transaction-level model.
module tb_command_receiver;
    import command_pkg::*;

    localparam int unsigned T    = 100;
    localparam int unsigned MAXA = 31;

    logic       clock = 1'b0;
    logic       reset;
    logic       has_data;
    logic [7:0] data_received;
    logic       command_ready;
    logic       command_valid;
    logic [7:0] command_code;
    logic [7:0] sensor_address;
    logic       error_flag;
    logic [1:0] error_code;
    logic [1:0] debug_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] obs_xfer[$];
    logic [15:0] exp_xfer[$];
    logic [1:0]  obs_err[$];
    logic [1:0]  exp_err[$];

    command_receiver #(.TIMEOUT_CLOCKS(T), .MAX_ADDRESS(MAXA)) dut (
        .clock          (clock),
        .reset          (reset),
        .has_data       (has_data),
        .data_received  (data_received),
        .command_ready  (command_ready),
        .command_valid  (command_valid),
        .command_code   (command_code),
        .sensor_address (sensor_address),
        .error_flag     (error_flag),
        .error_code     (error_code),
        .debug_state    (debug_state)
    );

    always #5 clock = ~clock;

    // Observed transfers and error pulses, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (error_flag === 1'b1) obs_err.push_back(error_code);
            if (command_valid === 1'b1 && command_ready === 1'b1)
                obs_xfer.push_back({command_code, sensor_address});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        has_data      = 1'b1;
        data_received = b;
        tick();
        has_data = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; has_data = 1'b0; data_received = 8'h00; command_ready = 1'b0;
        idle(3);
        n_cmp++;
        if ({command_valid, error_flag, error_code, debug_state, command_code, sensor_address} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b ef=%b ec=%b ds=%b cc=%h sa=%h want all zero",
                     command_valid, error_flag, error_code, debug_state, command_code, sensor_address);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_valid_frame();
        command_ready = 1'b1;
        send_byte(8'h01);
        n_cmp++;
        if (command_valid !== 1'b0 || debug_state !== 2'b00) begin
            n_bad++;
            $display("FAIL frame_after_byte1: got v=%b ds=%b want v=0 ds=00", command_valid, debug_state);
        end
        send_byte(8'h05);
        n_cmp++;
        if (command_valid !== 1'b1 || command_code !== 8'h01 || sensor_address !== 8'h05 ||
            error_flag !== 1'b0 || debug_state !== 2'b01) begin
            n_bad++;
            $display("FAIL frame_valid: got v=%b cc=%h sa=%h ef=%b ds=%b want 1 01 05 0 01",
                     command_valid, command_code, sensor_address, error_flag, debug_state);
        end
        tick();
        n_cmp++;
        if (command_valid !== 1'b0 || debug_state !== 2'b10 || error_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_one_cycle: got v=%b ds=%b ef=%b want 0 10 0", command_valid, debug_state, error_flag);
        end
        command_ready = 1'b0;
        tick();
    endtask

    task automatic test_invalid_command();
        send_byte(8'h09);
        n_cmp++;
        if (error_flag !== 1'b1 || error_code !== ERR_INVALID_COMMAND) begin
            n_bad++;
            $display("FAIL invcmd_pulse: got ef=%b ec=%b want 1 01", error_flag, error_code);
        end
        tick();
        n_cmp++;
        if (error_flag !== 1'b0 || error_code !== 2'b00 || debug_state !== 2'b00) begin
            n_bad++;
            $display("FAIL invcmd_after: got ef=%b ec=%b ds=%b want 0 00 00", error_flag, error_code, debug_state);
        end
        command_ready = 1'b1;
        send_byte(8'h00);
        send_byte(8'h00);
        n_cmp++;
        if (command_valid !== 1'b1 || command_code !== 8'h00 || sensor_address !== 8'h00) begin
            n_bad++;
            $display("FAIL invcmd_next_frame: got v=%b cc=%h sa=%h want 1 00 00", command_valid, command_code, sensor_address);
        end
        tick();
        command_ready = 1'b0;
    endtask

    task automatic test_invalid_address();
        command_ready = 1'b1;
        send_byte(8'h02);
        send_byte(8'h20);
        n_cmp++;
        if (error_flag !== 1'b1 || error_code !== ERR_INVALID_ADDRESS || command_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL invaddr_pulse: got ef=%b ec=%b v=%b want 1 10 0", error_flag, error_code, command_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (command_valid !== 1'b0 || error_flag !== 1'b0) begin
                n_bad++;
                $display("FAIL invaddr_quiet[%0d]: got v=%b ef=%b want 0 0", i, command_valid, error_flag);
            end
        end
        command_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int  k;
        bit  seen;
        bit  early;
        k = 0; seen = 1'b0;
        send_byte(8'h02);
        while (!seen && k < 2 * T) begin
            tick();
            k++;
            if (error_flag === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || k != T || error_code !== ERR_TIMEOUT) begin
            n_bad++;
            $display("FAIL timeout_cycle: got seen=%0b after %0d cycles ec=%b want pulse after %0d cycles ec=11",
                     seen, k, error_code, T);
        end
        tick();
        n_cmp++;
        if (error_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_one_cycle: got ef=%b want 0", error_flag);
        end
        // Second byte lands exactly on the expiry cycle.
        command_ready = 1'b1;
        early = 1'b0;
        send_byte(8'h02);
        repeat (T - 1) begin
            tick();
            if (error_flag === 1'b1) early = 1'b1;
        end
        send_byte(8'h03);
        n_cmp++;
        if (early || command_valid !== 1'b1 || error_flag !== 1'b0 || sensor_address !== 8'h03) begin
            n_bad++;
            $display("FAIL timeout_byte_wins: got early=%0b v=%b ef=%b sa=%h want 0 1 0 03",
                     early, command_valid, error_flag, sensor_address);
        end
        tick();
        command_ready = 1'b0;
        tick();
    endtask

    task automatic test_overrun();
        int n0;
        command_ready = 1'b0;
        send_byte(8'h03);
        send_byte(8'h07);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) send_byte(8'h01);
            else        tick();
            n_cmp++;
            if (command_valid !== 1'b1 || command_code !== 8'h03 || sensor_address !== 8'h07 ||
                error_flag !== (i == 5) || (i == 5 && error_code !== ERR_OVERRUN)) begin
                n_bad++;
                $display("FAIL overrun_hold[%0d]: got v=%b cc=%h sa=%h ef=%b ec=%b want 1 03 07 %0b 00",
                         i, command_valid, command_code, sensor_address, error_flag, error_code, (i == 5));
            end
        end
        n0 = obs_xfer.size();
        command_ready = 1'b1;
        tick();
        n_cmp++;
        if (command_valid !== 1'b0 || obs_xfer.size() != n0 + 1 ||
            (obs_xfer.size() > 0 && obs_xfer[obs_xfer.size() - 1] !== 16'h0307)) begin
            n_bad++;
            $display("FAIL overrun_transfer: got v=%b transfers=%0d want v=0 transfers=%0d of 0307",
                     command_valid, obs_xfer.size() - n0, 1);
        end
        // Byte arriving in the transfer cycle is still an overrun.
        command_ready = 1'b0;
        send_byte(8'h05);
        send_byte(8'h06);
        command_ready = 1'b1;
        send_byte(8'h01);
        n_cmp++;
        if (command_valid !== 1'b0 || error_flag !== 1'b1 || error_code !== ERR_OVERRUN) begin
            n_bad++;
            $display("FAIL overrun_on_transfer: got v=%b ef=%b ec=%b want 0 1 00", command_valid, error_flag, error_code);
        end
        command_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h04);
        reset = 1'b1;
        send_byte(8'h09);
        reset = 1'b0;
        n_cmp++;
        if ({command_valid, error_flag, error_code, debug_state, command_code, sensor_address} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_wait_address: got v=%b ef=%b ec=%b ds=%b cc=%h sa=%h want all zero",
                     command_valid, error_flag, error_code, debug_state, command_code, sensor_address);
        end
        tick();
        n_cmp++;
        if (error_flag !== 1'b0 || debug_state !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_wa_quiet: got ef=%b ds=%b want 0 00", error_flag, debug_state);
        end
        send_byte(8'h04);
        send_byte(8'h1F);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({command_valid, error_flag, error_code, debug_state, command_code, sensor_address} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_hold: got v=%b ef=%b ec=%b ds=%b cc=%h sa=%h want all zero",
                     command_valid, error_flag, error_code, debug_state, command_code, sensor_address);
        end
        tick();
        n_cmp++;
        if (error_flag !== 1'b0 || command_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold_quiet: got ef=%b v=%b want 0 0", error_flag, command_valid);
        end
        command_ready = 1'b1;
        send_byte(8'h04);
        send_byte(8'h1F);
        n_cmp++;
        if (command_valid !== 1'b1 || command_code !== 8'h04 || sensor_address !== 8'h1F || error_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_fresh_frame: got v=%b cc=%h sa=%h ef=%b want 1 04 1f 0",
                     command_valid, command_code, sensor_address, error_flag);
        end
        tick();
        command_ready = 1'b0;
        tick();
    endtask

    // Model: each frame yields exactly one outcome from the field/gap rules, plus one
    // overrun per byte thrown at a held command.
    task automatic test_random();
        logic [7:0] b1, b2;
        int         sel, gap, budget;
        obs_xfer.delete(); obs_err.delete();
        exp_xfer.delete(); exp_err.delete();
        for (int f = 0; f < 40; f++) begin
            b1  = 8'($urandom_range(0, 9));
            b2  = 8'($urandom_range(0, 40));
            sel = $urandom_range(0, 19);
            gap = (sel < 14) ? $urandom_range(0, 5) : (sel < 17) ? T - 1 : T;
            send_byte(b1);
            if (b1 > 8'd6) begin
                exp_err.push_back(ERR_INVALID_COMMAND);
            end else begin
                idle(gap);
                if (gap >= T) begin
                    exp_err.push_back(ERR_TIMEOUT);
                end else begin
                    send_byte(b2);
                    if (b2 > 8'(MAXA)) begin
                        exp_err.push_back(ERR_INVALID_ADDRESS);
                    end else begin
                        exp_xfer.push_back({b1, b2});
                        budget = 0;
                        while (command_valid === 1'b1 && budget < 64) begin
                            command_ready = 1'($urandom_range(0, 1));
                            if ($urandom_range(0, 7) == 0) begin
                                exp_err.push_back(ERR_OVERRUN);
                                send_byte(8'($urandom_range(0, 255)));
                            end else begin
                                tick();
                            end
                            budget++;
                        end
                        if (command_valid === 1'b1) begin
                            command_ready = 1'b1;
                            tick();
                        end
                    end
                end
            end
            command_ready = 1'b0;
            idle(2);
        end
        n_cmp++;
        if (obs_xfer.size() != exp_xfer.size() || obs_err.size() != exp_err.size()) begin
            n_bad++;
            $display("FAIL random_counts: got xfers=%0d errs=%0d want xfers=%0d errs=%0d",
                     obs_xfer.size(), obs_err.size(), exp_xfer.size(), exp_err.size());
        end else begin
            foreach (exp_xfer[i]) begin
                n_cmp++;
                if (obs_xfer[i] !== exp_xfer[i]) begin
                    n_bad++;
                    $display("FAIL random_xfer[%0d]: got %h want %h", i, obs_xfer[i], exp_xfer[i]);
                end
            end
            foreach (exp_err[i]) begin
                n_cmp++;
                if (obs_err[i] !== exp_err[i]) begin
                    n_bad++;
                    $display("FAIL random_err[%0d]: got %b want %b", i, obs_err[i], exp_err[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_invalid_command();
        test_invalid_address();
        test_timeout();
        test_overrun();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion within time limit want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
